pingpong_buf_ctrl: RTL

//  Ping-pong write/read controller for two encoder ram_bank instances (buffer 0/1).

---
 rtl/pingpong_buf_ctrl_if.sv | 50 +++++
 rtl/pingpong_buf_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// pingpong_buf_ctrl_if
//   Bundles the upstream stream, downstream stream and the shared ram_bank
//   write/read buses of the ping-pong buffer controller.
//
//   Stream in  : in_valid, in_ready, in_data
//   Stream out : out_valid, out_ready, out_data, out_last
//   Memory     : mem_waddr, mem_wdata, mem_wen0, mem_wen1 (write side)
//                mem_raddr, mem_rdata0, mem_rdata1          (read side)
//   Status     : buf_full (bit b set while buffer b is FULL or DRAINING)
//
//   master : the controller
//   slave  : everything around it (upstream, downstream, the two ram_banks)
// ---------------------------------------------------------------------------
interface pingpong_buf_ctrl_if #(
  parameter int BANK_DATA_WIDTH = 512,
  parameter int BANK_NUM        = 8,
  parameter int ADDR_WIDTH      = 10
);
  logic                       in_valid;
  logic                       in_ready;
  logic [BANK_DATA_WIDTH-1:0] in_data;

  logic                       out_valid;
  logic                       out_ready;
  logic [BANK_DATA_WIDTH-1:0] out_data;
  logic                       out_last;

  logic [ADDR_WIDTH-1:0]      mem_waddr;
  logic [BANK_DATA_WIDTH-1:0] mem_wdata;
  logic [BANK_NUM-1:0]        mem_wen0;
  logic [BANK_NUM-1:0]        mem_wen1;
  logic [ADDR_WIDTH-1:0]      mem_raddr;
  logic [BANK_DATA_WIDTH-1:0] mem_rdata0;
  logic [BANK_DATA_WIDTH-1:0] mem_rdata1;

  logic [1:0]                 buf_full;

  modport master (
    input  in_valid, in_data, out_ready, mem_rdata0, mem_rdata1,
    output in_ready, out_valid, out_data, out_last,
           mem_waddr, mem_wdata, mem_wen0, mem_wen1, mem_raddr, buf_full
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rdata0, mem_rdata1,
    input  in_ready, out_valid, out_data, out_last,
           mem_waddr, mem_wdata, mem_wen0, mem_wen1, mem_raddr, buf_full
  );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_buf_ctrl
//   Ping-pong controller for two ram_bank buffers. One buffer is filled from
//   the upstream valid/ready stream while the other is drained downstream.
//   Reads are issued against a credit check (FIFO occupancy + reads still in
//   the bank pipeline) so the small output FIFO can never overflow and
//   out_ready backpressure never drops a word.
//
// Ports
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : pingpong_buf_ctrl_if.master
//            in_valid/in_ready/in_data      upstream words
//            out_valid/out_ready/out_data/out_last  downstream words
//            mem_waddr/mem_wdata/mem_wen0/mem_wen1  shared write bus
//            mem_raddr/mem_rdata0/mem_rdata1        shared read bus
//            buf_full                       per-buffer FULL|DRAINING flag
// ---------------------------------------------------------------------------
module pingpong_buf_ctrl #(
  parameter int BANK_DATA_WIDTH = 512,
  parameter int BANK_NUM        = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int FRAME_LEN       = 1024,
  parameter int LATENCY         = 1,
  parameter int OUT_DEPTH       = LATENCY + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pingpong_buf_ctrl_if.master bus
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  // Wide enough for fifo count plus every in-flight read without wrapping.
  localparam int SUM_W = $clog2(OUT_DEPTH + LATENCY + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'd0,
    BUF_FILLING  = 2'd1,
    BUF_FULL     = 2'd2,
    BUF_DRAINING = 2'd3
  } buf_state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  buf_state_t            buf_state_reg  [2];
  buf_state_t            buf_state_next [2];
  logic                  wsel_reg, wsel_next;
  logic                  rsel_reg, rsel_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [ADDR_WIDTH-1:0] raddr_reg, raddr_next;

  // Read tag pipe: one stage per cycle of bank read latency.
  logic [LATENCY-1:0]    pipe_vld_reg, pipe_vld_next;
  logic [LATENCY-1:0]    pipe_sel_reg, pipe_sel_next;
  logic [LATENCY-1:0]    pipe_last_reg, pipe_last_next;

  // Output FIFO (small, head read combinationally).
  logic [BANK_DATA_WIDTH-1:0] fifo_data_reg [OUT_DEPTH];
  logic                       fifo_last_reg [OUT_DEPTH];
  logic [PTR_W-1:0]           fifo_wptr_reg, fifo_wptr_next;
  logic [PTR_W-1:0]           fifo_rptr_reg, fifo_rptr_next;
  logic [CNT_W-1:0]           fifo_cnt_reg, fifo_cnt_next;

  // Handshake / control
  logic                  wr_ok, rd_ok, credit_ok;
  logic                  wr_fire, rd_issue;
  logic [1:0]            wr_hit, rd_hit;
  logic                  waddr_last, raddr_last;
  logic [SUM_W-1:0]      inflight;
  logic                  cap_vld;
  logic [BANK_DATA_WIDTH-1:0] cap_data;
  logic                  cap_last;
  logic                  fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign waddr_last = (waddr_reg == LAST_ADDR);
  assign raddr_last = (raddr_reg == LAST_ADDR);

  // Reads issued but not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SUM_W'(pipe_vld_reg[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Output logic of the buffer FSMs and handshakes
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ok     = (buf_state_reg[wsel_reg] == BUF_EMPTY) ||
                (buf_state_reg[wsel_reg] == BUF_FILLING);
    rd_ok     = (buf_state_reg[rsel_reg] == BUF_FULL) ||
                (buf_state_reg[rsel_reg] == BUF_DRAINING);
    credit_ok = (SUM_W'(fifo_cnt_reg) + inflight) < SUM_W'(OUT_DEPTH);

    // Gated by rst_n so nothing handshakes on the reset edge itself.
    bus.in_ready  = rst_n && wr_ok;
    wr_fire       = bus.in_valid && bus.in_ready;
    rd_issue      = rst_n && rd_ok && credit_ok;
    bus.out_valid = rst_n && (fifo_cnt_reg != '0);

    bus.mem_waddr = waddr_reg;
    bus.mem_wdata = bus.in_data;
    bus.mem_wen0  = (wr_fire && !wsel_reg) ? {BANK_NUM{1'b1}} : '0;
    bus.mem_wen1  = (wr_fire &&  wsel_reg) ? {BANK_NUM{1'b1}} : '0;
    bus.mem_raddr = raddr_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign wr_hit[gi]       = wr_fire  && (wsel_reg == 1'(gi));
      assign rd_hit[gi]       = rd_issue && (rsel_reg == 1'(gi));
      assign bus.buf_full[gi] = (buf_state_reg[gi] == BUF_FULL) ||
                                (buf_state_reg[gi] == BUF_DRAINING);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      buf_state_next[b] = buf_state_reg[b];
      case (buf_state_reg[b])
        BUF_EMPTY:
          if (wr_hit[b]) buf_state_next[b] = waddr_last ? BUF_FULL : BUF_FILLING;
        BUF_FILLING:
          if (wr_hit[b] && waddr_last) buf_state_next[b] = BUF_FULL;
        BUF_FULL:
          if (rd_hit[b]) buf_state_next[b] = raddr_last ? BUF_EMPTY : BUF_DRAINING;
        BUF_DRAINING:
          if (rd_hit[b] && raddr_last) buf_state_next[b] = BUF_EMPTY;
        default:
          buf_state_next[b] = BUF_EMPTY;
      endcase
    end

    waddr_next = waddr_reg;
    wsel_next  = wsel_reg;
    if (wr_fire) begin
      if (waddr_last) begin
        waddr_next = '0;
        wsel_next  = ~wsel_reg;
      end else begin
        waddr_next = waddr_reg + ADDR_WIDTH'(1);
      end
    end

    raddr_next = raddr_reg;
    rsel_next  = rsel_reg;
    if (rd_issue) begin
      if (raddr_last) begin
        raddr_next = '0;
        rsel_next  = ~rsel_reg;
      end else begin
        raddr_next = raddr_reg + ADDR_WIDTH'(1);
      end
    end
  end

  // Tag pipe: stage 0 takes the new issue, later stages shift.
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_vld_next[gi]  = rd_issue;
        assign pipe_sel_next[gi]  = rsel_reg;
        assign pipe_last_next[gi] = raddr_last;
      end else begin : g_tail
        assign pipe_vld_next[gi]  = pipe_vld_reg[gi-1];
        assign pipe_sel_next[gi]  = pipe_sel_reg[gi-1];
        assign pipe_last_next[gi] = pipe_last_reg[gi-1];
      end
    end
  endgenerate

  // The last stage lines up with bank data for the read it tags.
  assign cap_vld  = pipe_vld_reg[LATENCY-1];
  assign cap_last = pipe_last_reg[LATENCY-1];
  assign cap_data = pipe_sel_reg[LATENCY-1] ? bus.mem_rdata1 : bus.mem_rdata0;

  // FIFO bookkeeping. The credit check guarantees a free slot on capture.
  assign fifo_pop = bus.out_valid && bus.out_ready;

  always_comb begin
    fifo_wptr_next = cap_vld  ? ptr_inc(fifo_wptr_reg) : fifo_wptr_reg;
    fifo_rptr_next = fifo_pop ? ptr_inc(fifo_rptr_reg) : fifo_rptr_reg;
    fifo_cnt_next  = fifo_cnt_reg;
    case ({cap_vld, fifo_pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
      2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  assign bus.out_data = fifo_data_reg[fifo_rptr_reg];
  assign bus.out_last = bus.out_valid && fifo_last_reg[fifo_rptr_reg];

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_state_reg[0] <= BUF_EMPTY;
      buf_state_reg[1] <= BUF_EMPTY;
      wsel_reg         <= 1'b0;
      rsel_reg         <= 1'b0;
      waddr_reg        <= '0;
      raddr_reg        <= '0;
      pipe_vld_reg     <= '0;
      pipe_sel_reg     <= '0;
      pipe_last_reg    <= '0;
      fifo_wptr_reg    <= '0;
      fifo_rptr_reg    <= '0;
      fifo_cnt_reg     <= '0;
    end else begin
      buf_state_reg[0] <= buf_state_next[0];
      buf_state_reg[1] <= buf_state_next[1];
      wsel_reg         <= wsel_next;
      rsel_reg         <= rsel_next;
      waddr_reg        <= waddr_next;
      raddr_reg        <= raddr_next;
      pipe_vld_reg     <= pipe_vld_next;
      pipe_sel_reg     <= pipe_sel_next;
      pipe_last_reg    <= pipe_last_next;
      fifo_wptr_reg    <= fifo_wptr_next;
      fifo_rptr_reg    <= fifo_rptr_next;
      fifo_cnt_reg     <= fifo_cnt_next;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (cap_vld) begin
      fifo_data_reg[fifo_wptr_reg] <= cap_data;
      fifo_last_reg[fifo_wptr_reg] <= cap_last;
    end
  end

endmodule
